// File: rtl/inst_loader.sv
// inst_loader: UART 8N1 receiver feeding a length-prefixed instruction-memory loader.
module inst_loader #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int INST_SIZE = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           mode,
  input  logic                 rxd,
  output logic                 we,
  output logic [INST_SIZE-1:0] waddr,
  output logic [31:0]          wdata,
  output logic                 done,
  output logic                 err
);
  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int CW = $clog2(BIT_CLKS);
  localparam logic [2:0] LOAD = 3'd1;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [1:0] {L_IDLE, L_HEADER, L_DATA, L_DONE} ld_t;
  rx_t rx_state, rx_next;
  ld_t l_state, l_next;
  logic [1:0] sync;
  logic rx_s;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] rx_sh;
  logic rx_valid;
  logic half_tick, bit_tick;
  logic [1:0] bcnt;
  logic [31:0] sh, n, k, word;
  logic load, active, byte_last;
  assign rx_s = sync[1];
  assign half_tick = cnt == CW'(CLK_PER_HALF_BIT - 1);
  assign bit_tick = cnt == CW'(BIT_CLKS - 1);
  assign load = mode == LOAD;
  assign active = load && (l_state == L_HEADER || l_state == L_DATA);
  assign byte_last = rx_valid && bcnt == 2'd3;
  // bytes arrive little-endian, so each new byte enters at the top
  assign word = {rx_sh, sh[31:8]};
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  rx_next = rx_s ? RX_IDLE : RX_START;
      RX_START: rx_next = !half_tick ? RX_START : (rx_s ? RX_IDLE : RX_DATA);
      RX_DATA:  rx_next = (bit_tick && bit_idx == 3'd7) ? RX_STOP : RX_DATA;
      RX_STOP:  rx_next = bit_tick ? RX_IDLE : RX_STOP;
      default:  rx_next = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      rx_state <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      rx_sh <= '0;
      rx_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      sync <= {sync[0], rxd};
      rx_state <= rx_next;
      rx_valid <= 1'b0;
      cnt <= (rx_next != rx_state || bit_tick) ? '0 : cnt + 1'b1;
      if (rx_state == RX_START) bit_idx <= '0;
      if (rx_state == RX_DATA && bit_tick) begin
        rx_sh <= {rx_s, rx_sh[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (rx_state == RX_STOP && bit_tick) begin
        rx_valid <= rx_s;
        err <= err | !rx_s;
      end
    end
  end
  always_comb begin
    l_next = l_state;
    case (l_state)
      L_IDLE:   l_next = (load && !done) ? L_HEADER : L_IDLE;
      L_HEADER: l_next = !load ? L_IDLE : (!byte_last ? L_HEADER : (word == '0 ? L_DONE : L_DATA));
      L_DATA:   l_next = !load ? L_IDLE : ((byte_last && k == n - 32'd1) ? L_DONE : L_DATA);
      default:  l_next = L_DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_state <= L_IDLE;
      bcnt <= '0;
      sh <= '0;
      n <= '0;
      k <= '0;
      we <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      done <= 1'b0;
    end else begin
      l_state <= l_next;
      we <= 1'b0;
      done <= l_next == L_DONE;
      if (l_state == L_IDLE) begin
        bcnt <= '0;
        n <= '0;
        k <= '0;
      end
      if (active && rx_valid) begin
        sh <= word;
        bcnt <= bcnt + 1'b1;
      end
      if (active && byte_last && l_state == L_HEADER) begin
        n <= word;
        k <= '0;
      end
      // words beyond the memory are counted but never written
      if (active && byte_last && l_state == L_DATA) begin
        k <= k + 32'd1;
        if (k[31:INST_SIZE] == '0) begin
          we <= 1'b1;
          waddr <= k[INST_SIZE-1:0];
          wdata <= word;
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: table-driven and hand-written load sequences with a write scoreboard.
module tb_inst_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] mode = 3'd0;
  logic rxd = 1'b1;
  logic we, done, err;
  logic [3:0] waddr;
  logic [31:0] wdata;
  int checks = 0;
  int errors = 0;
  int we_seen = 0;
  typedef struct {logic [3:0] a; logic [31:0] d; bit last;} exp_t;
  typedef struct {logic [31:0] n; int words; bit bad; int exp_we; bit exp_done; bit exp_err;} vec_t;
  exp_t q[$];
  vec_t vecs[6];

  inst_loader #(.CLK_PER_HALF_BIT(4), .INST_SIZE(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .rxd(rxd),
    .we(we), .waddr(waddr), .wdata(wdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (we) begin
      exp_t e;
      we_seen++;
      if (q.size() == 0) check("we_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        check("waddr", waddr, e.a);
        check("wdata", wdata, e.d);
        check("done_with_we", done, e.last);
      end
    end
  end

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rxd = 1'b1;
    q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input int k, input logic [31:0] w, input bit last);
    exp_t e;
    e.a = k[3:0];
    e.d = w;
    e.last = last;
    q.push_back(e);
  endtask

  initial begin
    int base;
    logic [31:0] w;
    vecs[0] = '{n: 32'd0, words: 0, bad: 1'b0, exp_we: 0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{n: 32'd1, words: 1, bad: 1'b0, exp_we: 1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{n: 32'd3, words: 3, bad: 1'b0, exp_we: 3, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{n: 32'd18, words: 18, bad: 1'b0, exp_we: 16, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{n: 32'd2, words: 2, bad: 1'b1, exp_we: 2, exp_done: 1'b1, exp_err: 1'b1};
    vecs[5] = '{n: 32'd3, words: 2, bad: 1'b0, exp_we: 2, exp_done: 1'b0, exp_err: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      do_reset();
      mode = 3'd1;
      base = we_seen;
      if (vecs[v].bad) send_byte(8'hA5, 1'b0);
      send_word(vecs[v].n);
      for (int k = 0; k < vecs[v].words; k++) begin
        w = $urandom;
        if (k < 16) push(k, w, k == int'(vecs[v].n) - 1);
        send_word(w);
      end
      repeat (10) @(negedge clk);
      check($sformatf("vec%0d_we_count", v), we_seen - base, vecs[v].exp_we);
      check($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
      check($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
      check($sformatf("vec%0d_queue", v), q.size(), 0);
    end

    do_reset();
    mode = 3'd1;
    base = we_seen;
    push(0, 32'h00000013, 1'b0);
    push(1, 32'hDEADBEEF, 1'b1);
    send_word(32'd2);
    send_word(32'h00000013);
    send_word(32'hDEADBEEF);
    repeat (10) @(negedge clk);
    check("two_we_count", we_seen - base, 2);
    check("two_done", done, 1);
    check("two_err", err, 0);
    check("two_hold_waddr", waddr, 1);
    check("two_hold_wdata", wdata, 32'hDEADBEEF);
    send_word(32'h12345678);
    repeat (10) @(negedge clk);
    check("after_done_no_we", we_seen - base, 2);
    check("after_done_sticky", done, 1);

    do_reset();
    mode = 3'd1;
    base = we_seen;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_err", err, 0);
    check("glitch_done", done, 0);
    push(0, 32'hCAFE0001, 1'b1);
    send_word(32'd1);
    send_word(32'hCAFE0001);
    repeat (10) @(negedge clk);
    check("glitch_we_count", we_seen - base, 1);
    check("glitch_then_done", done, 1);

    do_reset();
    mode = 3'd1;
    base = we_seen;
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    mode = 3'd0;
    repeat (10) @(negedge clk);
    check("mode_drop_done", done, 0);
    mode = 3'd1;
    push(0, 32'h00000001, 1'b1);
    send_word(32'd1);
    send_word(32'h00000001);
    repeat (10) @(negedge clk);
    check("mode_drop_we_count", we_seen - base, 1);
    check("mode_drop_done_after", done, 1);

    do_reset();
    mode = 3'd1;
    base = we_seen;
    w = 32'h0BADF00D;
    push(0, w, 1'b0);
    send_word(32'd2);
    send_word(w);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    check("midword_rst_done", done, 0);
    check("midword_rst_waddr", waddr, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midword_we_count", we_seen - base, 1);
    check("midword_queue", q.size(), 0);
    push(0, 32'h00C0FFEE, 1'b1);
    send_word(32'd1);
    send_word(32'h00C0FFEE);
    repeat (10) @(negedge clk);
    check("midword_reload_we", we_seen - base, 2);
    check("midword_reload_done", done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
